// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer between fetch and decode.
// Circular FIFO of fetched words, presenting the oldest ISSUE_W to decode.
module cpu7_ifu_ibuf #(
  parameter int DEPTH   = 8,
  parameter int ISSUE_W = 2,
  parameter int GRLEN   = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 fq_valid,
  input  logic [GRLEN-1:0]     fq_pc,
  input  logic [1:0]           fq_count,
  input  logic [127:0]         fq_rdata,
  input  logic                 fq_ex,
  input  logic [5:0]           fq_exccode,
  output logic                 fq_ready,
  input  logic                 flush,
  input  logic                 stall,
  input  logic [2:0]           dec_take,
  output logic [ISSUE_W-1:0]   dec_valid,
  output logic [32*ISSUE_W-1:0]    dec_inst,
  output logic [GRLEN*ISSUE_W-1:0] dec_pc,
  output logic [ISSUE_W-1:0]   dec_ex,
  output logic [6*ISSUE_W-1:0] dec_exccode,
  output logic [AW:0]          occupancy
);

  logic [31:0]      inst_q [DEPTH];
  logic [GRLEN-1:0] pc_q   [DEPTH];
  logic             ex_q   [DEPTH];
  logic [5:0]       exc_q  [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   occ_q;
  logic [AW:0]   free;
  logic          wr_en;
  logic [2:0]    n_wr, n_wr_eff;
  logic [2:0]    n_val, n_rd;
  logic [AW-1:0] widx [4];

  assign occupancy = occ_q;

  // Ready depends only on registered occupancy so fetch sees no comb path.
  always_comb begin
    free     = (AW+1)'(DEPTH) - occ_q;
    fq_ready = free >= (AW+1)'(4);
  end

  // Write count: an excepting group collapses to a single marker entry.
  always_comb begin
    wr_en    = fq_valid & fq_ready & ~flush;
    n_wr     = fq_ex ? 3'd1 : {1'b0, fq_count} + 3'd1;
    n_wr_eff = wr_en ? n_wr : 3'd0;
    for (int k = 0; k < 4; k++)
      widx[k] = wptr_q + AW'(k);
  end

  // Consume count is clamped to what decode can actually see.
  always_comb begin
    if (occ_q >= (AW+1)'(ISSUE_W))
      n_val = 3'(ISSUE_W);
    else
      n_val = 3'(occ_q);
    if (stall)
      n_rd = 3'd0;
    else if (dec_take < n_val)
      n_rd = dec_take;
    else
      n_rd = n_val;
  end

  // Pointer and occupancy bookkeeping; flush wins over everything.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(n_wr_eff);
      rptr_q <= rptr_q + AW'(n_rd);
      occ_q  <= occ_q + (AW+1)'(n_wr_eff) - (AW+1)'(n_rd);
    end
  end

  // Entry storage; word k of a group lands at wptr+k with pc+4k.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < DEPTH; e++) begin
        inst_q[e] <= '0;
        pc_q[e]   <= '0;
        ex_q[e]   <= 1'b0;
        exc_q[e]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en && (3'(k) < n_wr)) begin
          inst_q[widx[k]] <= fq_ex ? 32'd0 : fq_rdata[32*k +: 32];
          pc_q[widx[k]]   <= fq_pc + GRLEN'(4 * k);
          ex_q[widx[k]]   <= fq_ex;
          exc_q[widx[k]]  <= fq_ex ? fq_exccode : 6'd0;
        end
      end
    end
  end

  // Slot i shows the i-th oldest entry; empty slots read as zero.
  always_comb begin
    dec_valid   = '0;
    dec_inst    = '0;
    dec_pc      = '0;
    dec_ex      = '0;
    dec_exccode = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (occ_q > (AW+1)'(i)) begin
        dec_valid[i]            = 1'b1;
        dec_inst[32*i +: 32]    = inst_q[rptr_q + AW'(i)];
        dec_pc[GRLEN*i +: GRLEN] = pc_q[rptr_q + AW'(i)];
        dec_ex[i]               = ex_q[rptr_q + AW'(i)];
        dec_exccode[6*i +: 6]   = exc_q[rptr_q + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Directed bench for the instruction buffer.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cpu7_ifu_ibuf;

  logic         clock = 1'b0;
  logic         resetn;
  logic         fq_valid;
  logic [31:0]  fq_pc;
  logic [1:0]   fq_count;
  logic [127:0] fq_rdata;
  logic         fq_ex;
  logic [5:0]   fq_exccode;
  logic         fq_ready;
  logic         flush;
  logic         stall;
  logic [2:0]   dec_take;
  logic [1:0]   dec_valid;
  logic [63:0]  dec_inst;
  logic [63:0]  dec_pc;
  logic [1:0]   dec_ex;
  logic [11:0]  dec_exccode;
  logic [3:0]   occupancy;

  int n_chk  = 0;
  int n_pass = 0;

  cpu7_ifu_ibuf dut (
    .clock(clock), .resetn(resetn),
    .fq_valid(fq_valid), .fq_pc(fq_pc),
    .fq_count(fq_count), .fq_rdata(fq_rdata),
    .fq_ex(fq_ex), .fq_exccode(fq_exccode),
    .fq_ready(fq_ready), .flush(flush),
    .stall(stall), .dec_take(dec_take),
    .dec_valid(dec_valid), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_ex(dec_ex),
    .dec_exccode(dec_exccode),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fq_valid = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    dec_take = 3'd0;
    fq_ex    = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    fq_pc      = '0;
    fq_count   = '0;
    fq_rdata   = '0;
    fq_exccode = '0;
    idle();
    #1;
    chk("rst_occ",   64'(occupancy), 64'd0);
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_ready", 64'(fq_ready),  64'd1);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // fill with two 4-word groups while decode stalls
    stall    = 1'b1;
    fq_valid = 1'b1;
    fq_count = 2'd3;
    fq_pc    = 32'h1c00_0000;
    fq_rdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick();
    chk("fill1_occ",   64'(occupancy), 64'd4);
    chk("fill1_ready", 64'(fq_ready),  64'd1);
    fq_pc    = 32'h1c00_0010;
    fq_rdata = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    tick();
    chk("fill_occ",   64'(occupancy), 64'd8);
    chk("fill_ready", 64'(fq_ready),  64'd0);
    chk("fill_pc",    dec_pc, {32'h1c00_0004, 32'h1c00_0000});
    chk("fill_inst",  dec_inst, {32'hA1, 32'hA0});
    fq_pc = 32'h1c00_0020;
    tick();
    chk("full_ignore_occ", 64'(occupancy), 64'd8);
    do_flush();
    chk("fl0_occ", 64'(occupancy), 64'd0);

    // partial group of two words
    fq_valid = 1'b1;
    fq_count = 2'd1;
    fq_pc    = 32'h100;
    fq_rdata = {32'h0, 32'h0, 32'hC1, 32'hC0};
    tick();
    idle();
    chk("part_occ",   64'(occupancy), 64'd2);
    chk("part_valid", 64'(dec_valid), 64'd3);
    chk("part_pc",    dec_pc, {32'h104, 32'h100});

    // reach occupancy 3, then write 4 while taking 2
    fq_valid = 1'b1;
    fq_count = 2'd0;
    fq_pc    = 32'h200;
    fq_rdata = {96'h0, 32'hD0};
    tick();
    chk("wc_pre_occ", 64'(occupancy), 64'd3);
    fq_count = 2'd3;
    fq_pc    = 32'h300;
    fq_rdata = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    dec_take = 3'd2;
    tick();
    idle();
    chk("wc_occ",  64'(occupancy), 64'd5);
    chk("wc_pc",   dec_pc, {32'h300, 32'h200});
    chk("wc_inst", dec_inst, {32'hE0, 32'hD0});
    stall    = 1'b1;
    dec_take = 3'd3;
    tick();
    chk("stall_occ", 64'(occupancy), 64'd5);
    stall = 1'b0;
    tick();
    idle();
    chk("clamp_occ", 64'(occupancy), 64'd3);
    chk("clamp_pc",  dec_pc, {32'h308, 32'h304});

    // flush beats simultaneous write and consume
    fq_valid = 1'b1;
    fq_count = 2'd3;
    fq_pc    = 32'h380;
    dec_take = 3'd2;
    flush    = 1'b1;
    tick();
    idle();
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(dec_valid), 64'd0);
    chk("flush_ready", 64'(fq_ready),  64'd1);
    fq_valid = 1'b1;
    fq_count = 2'd0;
    fq_pc    = 32'h400;
    tick();
    idle();
    chk("postfl_pc", dec_pc, {32'h0, 32'h400});
    do_flush();

    // exception group becomes a single marker entry
    fq_valid   = 1'b1;
    fq_ex      = 1'b1;
    fq_exccode = 6'h08;
    fq_count   = 2'd3;
    fq_pc      = 32'h500;
    fq_rdata   = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    tick();
    idle();
    chk("ex_occ",   64'(occupancy),   64'd1);
    chk("ex_valid", 64'(dec_valid),   64'd1);
    chk("ex_flag",  64'(dec_ex),      64'd1);
    chk("ex_code",  64'(dec_exccode), 64'h008);
    chk("ex_inst",  dec_inst,         64'd0);
    chk("ex_pc",    dec_pc,           {32'h0, 32'h500});
    do_flush();

    // stream of single words through the ring, wrapping twice
    fq_count = 2'd0;
    dec_take = 3'd1;
    for (int j = 0; j < 20; j++) begin
      fq_valid = 1'b1;
      fq_pc    = 32'h1000 + 32'(4 * j);
      fq_rdata = {96'h0, 32'h5000 + 32'(j)};
      tick();
      chk("wrap_pc",   64'(dec_pc[31:0]),   64'(32'h1000 + 32'(4 * j)));
      chk("wrap_inst", 64'(dec_inst[31:0]), 64'(32'h5000 + 32'(j)));
      chk("wrap_occ",  64'(occupancy <= 4'd2), 64'd1);
    end
    fq_valid = 1'b0;
    tick();
    idle();
    chk("wrap_drain", 64'(occupancy), 64'd0);

    // reset in the middle of traffic
    fq_valid = 1'b1;
    fq_count = 2'd3;
    fq_pc    = 32'h600;
    tick();
    chk("mid_occ", 64'(occupancy), 64'd4);
    resetn   = 1'b0;
    dec_take = 3'd1;
    #1;
    chk("mid_rst_occ",   64'(occupancy), 64'd0);
    chk("mid_rst_valid", 64'(dec_valid), 64'd0);
    chk("mid_rst_ready", 64'(fq_ready),  64'd1);
    tick();
    idle();
    resetn = 1'b1;
    tick();
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    fq_valid = 1'b1;
    fq_count = 2'd0;
    fq_pc    = 32'h700;
    fq_rdata = {96'h0, 32'h77};
    tick();
    idle();
    chk("post_rst_pc",  dec_pc, {32'h0, 32'h700});
    chk("post_rst_ex",  64'(dec_ex), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_ibuf.md
CPU7_IFU_IBUF -- requirements
Module: cpu7_ifu_ibuf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of 2, >= 4.
REQ-002 SHALL have parameter ISSUE_W, default 2, decode slots presented per cycle; 1..4.
REQ-003 SHALL have parameter GRLEN, default 32, PC width.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port fq_valid  input  1  fetch group valid this cycle.
REQ-007 SHALL have port fq_pc  input  GRLEN  PC of word 0 of the group.
REQ-008 SHALL have port fq_count  input  2  valid words in group, minus 1 (0 = 1 word, 3 = 4 words).
REQ-009 SHALL have port fq_rdata  input  128  words; word i = bits [32i+31:32i].
REQ-010 SHALL have port fq_ex  input  1  fetch exception on this group.
REQ-011 SHALL have port fq_exccode  input  6  exception code.
REQ-012 SHALL have port fq_ready  output  1  buffer can accept a 4-word group.
REQ-013 SHALL have port flush  input  1  branch taken / redirect; discard contents.
REQ-014 SHALL have port stall  input  1  decode stall; no consumption.
REQ-015 SHALL have port dec_take  input  3  slots consumed this cycle.
REQ-016 SHALL have port dec_valid  output  ISSUE_W  slot i holds an entry.
REQ-017 SHALL have port dec_inst  output  32*ISSUE_W  instruction per slot.
REQ-018 SHALL have port dec_pc  output  GRLEN*ISSUE_W  PC per slot.
REQ-019 SHALL have port dec_ex  output  ISSUE_W  exception flag per slot.
REQ-020 SHALL have port dec_exccode  output  6*ISSUE_W  exccode per slot.
REQ-021 SHALL have port occupancy  output  log2(DEPTH)+1  current entry count.

Function
REQ-022 SHALL be a circular FIFO of DEPTH entries {inst, pc, ex, exccode} with read/write pointers wrapping modulo DEPTH.
REQ-023 SHALL drive fq_ready = (DEPTH - occupancy) >= 4, from registered occupancy only.
REQ-024 SHALL, on write (fq_valid & fq_ready & !flush, fq_ex=0), append fq_count+1 entries in order; entry k: inst = word k, pc = fq_pc + 4k.
REQ-025 SHALL, on write with fq_ex=1, append exactly one entry: inst = 0, pc = fq_pc, ex = 1, exccode = fq_exccode.
REQ-026 SHALL ignore fq_valid while fq_ready = 0 (no write, no error).
REQ-027 SHALL present the i-th oldest entry on slot i; dec_valid[i] = (occupancy > i); invalid slots drive zeros.
REQ-028 SHALL make written entries visible on dec_* one cycle after the write edge (no bypass).
REQ-029 SHALL consume min(dec_take, number of valid slots) entries when stall = 0; none when stall = 1.
REQ-030 SHALL update occupancy = occupancy + written - consumed when write and consume coincide.
REQ-031 SHALL, on flush, clear both pointers and occupancy at the next edge; flush overrides same-cycle write and consume.
REQ-032 SHALL deassert all dec_valid the cycle after flush and assert fq_ready.
REQ-033 SHALL never overflow or underflow; occupancy stays in 0..DEPTH.

Reset
REQ-034 SHALL, while resetn = 0, force pointers = 0, occupancy = 0, dec_valid = 0, fq_ready = 1, stored ex bits = 0.
REQ-035 SHALL discard any in-flight write or consume when reset asserts mid-operation; first write after release lands at entry 0.

Verification
REQ-036 SHALL cover fill: 2 groups, fq_pc=0x1c000000, fq_count=3, stall=1 -> occupancy=8, fq_ready=0, slot0 pc=0x1c000000, slot1 pc=0x1c000004.
REQ-037 SHALL cover partial group: fq_count=1, fq_pc=0x100 -> occupancy=2, slots pc 0x100/0x104, dec_valid=2'b11 next cycle.
REQ-038 SHALL cover simultaneous write and consume: occupancy=3, write 4 words, dec_take=2 -> occupancy=5.
REQ-039 SHALL cover flush with write and consume active in the same cycle -> occupancy=0, dec_valid=0 next cycle, fq_ready=1.
REQ-040 SHALL cover exception: fq_ex=1, fq_exccode=6'h08, fq_count=3 -> one entry, dec_ex[0]=1, dec_exccode=6'h08, inst=0.
REQ-041 SHALL cover wrap-around: 20 single-word writes with dec_take=1 each cycle -> PCs emerge in order, occupancy never exceeds 2.
